fp32_bf16_vec_cvt: RTL and testbench

FP32_BF16_VEC_CVT -- requirements
Module: fp32_bf16_vec_cvt

---
 rtl/fp32_bf16_vec_cvt.sv | 194 +++++++++++++++++++
 tb/tb_fp32_bf16_vec_cvt.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_bf16_vec_cvt.sv
// fp32_bf16_vec_cvt: LANES-wide FP32 -> BF16 converter, two pipeline stages
// with a single global stall.
//   clk, reset        clock; asynchronous active-high reset
//   in_valid/in_ready input handshake; in_ready = out_ready | ~out_valid
//   in_data           LANES x FP32, lane i at [32i+31:32i]
//   in_lane_en        per-lane enable (disabled lanes give 0, no flags)
//   in_rm             0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 -> RNE + NV
//   in_tag            sideband tag returned with the result
//   out_valid/out_ready output handshake
//   out_data          LANES x BF16, lane i at [16i+15:16i]
//   out_flags         {NV,OF,UF,NX} OR over enabled lanes
//   out_tag           tag of the transaction on out_data
//   fflags/fflags_clr sticky flags, cleared synchronously (clear wins)

// Per-lane converter: stage-1 decode register plus the stage-2 rounding
// logic. The stage-2 register lives in the top so flags can be OR-reduced.
module fp32_bf16_lane (
  input  logic        clk,
  input  logic        reset,
  input  logic        s1_load,
  input  logic        lane_en,
  input  logic [31:0] op,
  input  logic [2:0]  rm,      // stage-1 registered, already legalised
  output logic [15:0] res,
  output logic [3:0]  flags
);
  localparam logic [2:0] RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3,
                         RM_RMM = 3'd4;

  typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_QNAN, C_SNAN} cls_e;

  typedef struct packed {
    logic       en;
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
    logic       guard;
    logic       sticky;
    cls_e       cls;
  } s1_t;

  s1_t         dec, s1;
  logic        inexact, tz, inc, ovf;
  logic [14:0] sum;

  always_comb begin
    dec.en     = lane_en;
    dec.sign   = op[31];
    dec.exp    = op[30:23];
    dec.man    = op[22:16];
    dec.guard  = op[15];
    dec.sticky = |op[14:0];
    if (op[30:23] == 8'hFF)
      dec.cls = (op[22:0] == 23'd0) ? C_INF : (op[22] ? C_QNAN : C_SNAN);
    else if (op[30:23] == 8'h00)
      dec.cls = (op[22:0] == 23'd0) ? C_ZERO : C_SUB;
    else
      dec.cls = C_NORM;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)        s1 <= '0;
    else if (s1_load) s1 <= dec;

  always_comb begin
    inexact = s1.guard | s1.sticky;
    // modes that round this sign toward zero
    tz = (rm == RM_RTZ) | ((rm == RM_RUP) & s1.sign) | ((rm == RM_RDN) & ~s1.sign);
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1.sign & inexact;
      RM_RUP:  inc = ~s1.sign & inexact;
      RM_RMM:  inc = s1.guard;
      default: inc = s1.guard & (s1.sticky | s1.man[0]);
    endcase
    // carry out of the mantissa ripples straight into the exponent field,
    // which also moves a rounded-up subnormal into exponent 1
    sum = {s1.exp, s1.man} + {14'd0, inc};
    // a toward-zero mode never increments, so its overflow is the value
    // lying beyond max finite, which clamps to max finite
    ovf = (sum[14:7] == 8'hFF) | (tz & inexact & ({s1.exp, s1.man} == 15'h7F7F));

    res   = 16'h0000;
    flags = 4'h0;
    if (s1.en) begin
      case (s1.cls)
        C_QNAN:        res = 16'h7FC0;
        C_SNAN: begin  res = 16'h7FC0; flags = 4'b1000; end
        C_ZERO, C_INF: res = {s1.sign, s1.exp, s1.man};
        default: begin
          if (ovf) begin
            res   = {s1.sign, (tz ? 15'h7F7F : 15'h7F80)};
            flags = 4'b0101;
          end else begin
            res   = {s1.sign, sum};
            flags = {2'b00, inexact & (s1.exp == 8'h00), inexact};
          end
        end
      endcase
    end
  end
endmodule

module fp32_bf16_vec_cvt #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_data,
  input  logic [LANES-1:0]      in_lane_en,
  input  logic [2:0]            in_rm,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   out_data,
  output logic [3:0]            out_flags,
  output logic [TAG_W-1:0]      out_tag,
  output logic [3:0]            fflags,
  input  logic                  fflags_clr
);
  localparam int STAGES = 2;

  logic [STAGES:1]          vld_pipe;
  logic                     in_fire, s2_load;
  logic [2:0]               s1_rm;
  logic                     s1_rm_bad;
  logic [TAG_W-1:0]         s1_tag, tag_q;
  logic [LANES-1:0][15:0]   lane_res, data_q;
  logic [LANES-1:0][3:0]    lane_flags;
  logic [3:0]               flags_or, flags_q, fflags_q;

  assign out_valid = vld_pipe[STAGES];
  assign in_ready  = out_ready | ~out_valid;
  assign in_fire   = in_valid & in_ready;
  assign s2_load   = in_ready & vld_pipe[1];

  always_ff @(posedge clk or posedge reset)
    if (reset)         vld_pipe <= '0;
    else if (in_ready) vld_pipe <= {vld_pipe[STAGES-1:1], in_fire};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_rm     <= '0;
      s1_rm_bad <= 1'b0;
      s1_tag    <= '0;
    end else if (in_fire) begin
      s1_rm_bad <= (in_rm > 3'd4);
      s1_rm     <= (in_rm > 3'd4) ? 3'd0 : in_rm;
      s1_tag    <= in_tag;
    end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp32_bf16_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .s1_load (in_fire),
      .lane_en (in_lane_en[i]),
      .op      (in_data[32*i +: 32]),
      .rm      (s1_rm),
      .res     (lane_res[i]),
      .flags   (lane_flags[i])
    );
  end

  // a reserved mode poisons the whole transaction with NV
  always_comb begin
    flags_or = {s1_rm_bad, 3'b000};
    for (int i = 0; i < LANES; i++) flags_or = flags_or | lane_flags[i];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q  <= '0;
      flags_q <= '0;
      tag_q   <= '0;
    end else if (s2_load) begin
      data_q  <= lane_res;
      flags_q <= flags_or;
      tag_q   <= s1_tag;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset)                        fflags_q <= '0;
    else if (fflags_clr)              fflags_q <= '0;
    else if (out_valid && out_ready)  fflags_q <= fflags_q | flags_q;

  assign out_data  = data_q;
  assign out_flags = flags_q;
  assign out_tag   = tag_q;
  assign fflags    = fflags_q;
endmodule

// File: tb/tb_fp32_bf16_vec_cvt.sv
module tb_fp32_bf16_vec_cvt;
  localparam int LANES = 4;
  localparam int TAG_W = 4;
  localparam int NV = 17;

  logic         clk, reset, in_valid, in_ready, out_valid, out_ready, fflags_clr;
  logic [127:0] in_data;
  logic [3:0]   in_lane_en, out_flags, fflags;
  logic [2:0]   in_rm;
  logic [3:0]   in_tag, out_tag;
  logic [63:0]  out_data;

  fp32_bf16_vec_cvt #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lane_en(in_lane_en), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .out_tag(out_tag), .fflags(fflags), .fflags_clr(fflags_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  f;
    logic [3:0]  t;
  } exp_t;

  exp_t        q[$];
  int          errors = 0, checks = 0, delivered = 0;
  logic [3:0]  model_ff = 4'h0;
  logic        stall = 1'b0;
  logic [63:0] snap_d;
  logic [3:0]  snap_f, snap_t;

  // directed vectors: operand, mode, hand-computed BF16 and {NV,OF,UF,NX}
  logic [31:0] tv_x  [NV] = '{32'h3F808000, 32'h3F808000, 32'h3F818000, 32'h7F7FFFFF,
                              32'h7F7FFFFF, 32'h7F800001, 32'h7FC00000, 32'hFF800000,
                              32'h80000000, 32'h00400000, 32'h00000001, 32'h007FFFFF,
                              32'hBF808000, 32'hBF808000, 32'hFF7FFFFF, 32'h3F800000,
                              32'h3F808000};
  logic [2:0]  tv_rm [NV] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0,
                              3'd0, 3'd3, 3'd0, 3'd2, 3'd4, 3'd3, 3'd1, 3'd5};
  logic [15:0] tv_res[NV] = '{16'h3F80, 16'h3F81, 16'h3F82, 16'h7F80, 16'h7F7F,
                              16'h7FC0, 16'h7FC0, 16'hFF80, 16'h8000, 16'h0040,
                              16'h0001, 16'h0080, 16'hBF81, 16'hBF81, 16'hFF7F,
                              16'h3F80, 16'h3F80};
  logic [3:0]  tv_f  [NV] = '{4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'h8, 4'h0, 4'h0, 4'h0,
                              4'h0, 4'h3, 4'h3, 4'h1, 4'h1, 4'h5, 4'h0, 4'h1};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Value-level model: the kept half is the top 16 bits of the FP32 word,
  // the discarded half decides the rounding by plain comparison.
  function automatic logic [19:0] model_lane(input logic [31:0] x, input logic [2:0] rm);
    logic [15:0] keep, rem, mag;
    logic        sign, up, tz;
    logic [2:0]  r;
    r    = (rm > 3'd4) ? 3'd0 : rm;
    keep = x[31:16];
    rem  = x[15:0];
    sign = x[31];
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] != 23'd0) return {(x[22] ? 4'b0000 : 4'b1000), 16'h7FC0};
      return {4'b0000, keep};
    end
    if (rem == 16'h0) return {4'b0000, keep};
    case (r)
      3'd0:    up = (rem > 16'h8000) || (rem == 16'h8000 && keep[0]);
      3'd1:    up = 1'b0;
      3'd2:    up = sign;
      3'd3:    up = !sign;
      default: up = (rem >= 16'h8000);
    endcase
    tz  = !up && (r == 3'd1 || r == 3'd2 || r == 3'd3);
    mag = {1'b0, keep[14:0]} + {15'd0, up};
    if (mag >= 16'h7F80) return {4'b0101, sign, 15'h7F80};
    if (tz && keep[14:0] == 15'h7F7F) return {4'b0101, sign, 15'h7F7F};
    return {2'b00, (x[30:23] == 8'h00), 1'b1, sign, mag[14:0]};
  endfunction

  function automatic exp_t model_txn(input logic [127:0] d, input logic [3:0] en,
                                     input logic [2:0] rm, input logic [3:0] tag);
    exp_t        e;
    logic [19:0] r;
    e.d = '0;
    e.f = (rm > 3'd4) ? 4'b1000 : 4'b0000;
    e.t = tag;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) begin
        r = model_lane(d[32*i +: 32], rm);
        e.d[16*i +: 16] = r[15:0];
        e.f = e.f | r[19:16];
      end
    end
    return e;
  endfunction

  // one bench cycle: drive at the falling edge, then book-keep what the
  // coming rising edge will do
  task automatic step(input logic v, input logic [127:0] d, input logic [3:0] en,
                      input logic [2:0] rm, input logic [3:0] tag, input logic ordy,
                      input logic clr, output logic acc);
    @(negedge clk);
    in_valid = v; in_data = d; in_lane_en = en; in_rm = rm; in_tag = tag;
    out_ready = ordy; fflags_clr = clr;
    #1;
    chk("in_ready", in_ready, out_ready || !out_valid);
    acc = v && in_ready;
    if (acc) q.push_back(model_txn(d, en, rm, tag));
    if (clr) model_ff = 4'h0;
    else if (out_valid && out_ready && q.size() > 0) model_ff = model_ff | q[0].f;
    if (out_valid && out_ready && q.size() > 0) begin
      void'(q.pop_front());
      delivered++;
    end
    stall  = out_valid && !out_ready;
    snap_d = out_data; snap_f = out_flags; snap_t = out_tag;
  endtask

  function automatic logic [127:0] vec(input int i);
    return {tv_x[(i + 11) % NV], tv_x[(i + 7) % NV], tv_x[(i + 3) % NV], tv_x[i % NV]};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
        else begin
          chk("out_data", out_data, q[0].d);
          chk("out_flags", out_flags, q[0].f);
          chk("out_tag", out_tag, q[0].t);
        end
      end
      if (stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, snap_d);
        chk("stall_flags", out_flags, snap_f);
        chk("stall_tag", out_tag, snap_t);
      end
      chk("fflags", fflags, model_ff);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [19:0] r;
    exp_t        e;
    int          idx, cyc;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_lane_en = '0; in_rm = '0;
    in_tag = '0; out_ready = 1'b1; fflags_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_out_flags", out_flags, 4'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_fflags", fflags, 4'h0);
    @(negedge clk); #2 reset = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1'b1);

    // pin the model against hand-computed values
    for (int i = 0; i < NV; i++) begin
      r = model_lane(tv_x[i], tv_rm[i]);
      chk($sformatf("pin%0d", i), {44'h0, r}, {44'h0, tv_f[i], tv_res[i]});
    end
    e = model_txn({32'h7FC00000, 32'h3F800000, 32'h7F800001, 32'h3F808000}, 4'b0101, 3'd0, 4'h3);
    chk("pin_mask_d", e.d, 64'h0000_3F80_0000_3F80);
    chk("pin_mask_f", e.f, 4'b0001);
    e = model_txn({96'h0, 32'h3F808000}, 4'hF, 3'd5, 4'h4);
    chk("pin_rsv_f", e.f, 4'b1001);

    // latency: nothing after one edge, result after two
    step(1'b1, {96'h0, tv_x[0]}, 4'hF, 3'd0, 4'hA, 1'b1, 1'b0, acc);
    step(1'b0, '0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0, acc);
    chk("lat1", out_valid, 1'b0);
    step(1'b0, '0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0, acc);
    chk("lat2", out_valid, 1'b1);

    // directed vectors back to back
    for (int i = 0; i < NV; i++)
      step(1'b1, vec(i), 4'hF, tv_rm[i], i[3:0], 1'b1, 1'b0, acc);
    step(1'b1, {32'h7FC00000, 32'h3F800000, 32'h7F800001, 32'h3F808000}, 4'b0101,
         3'd0, 4'h3, 1'b1, 1'b0, acc);
    step(1'b1, {96'h0, 32'h3F808000}, 4'hF, 3'd5, 4'h4, 1'b1, 1'b0, acc);
    repeat (4) step(1'b0, '0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0, acc);
    step(1'b0, '0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b1, acc);

    // eight transactions under a 1,0,0,1 out_ready pattern
    delivered = 0; idx = 0; cyc = 0;
    while ((idx < 8 || q.size() > 0) && cyc < 200) begin
      step(idx < 8, vec(idx + 4), 4'hF, tv_rm[(idx + 4) % NV], 4'(idx + 3),
           (cyc % 4 == 0) || (cyc % 4 == 3), (cyc == 6), acc);
      if (acc) idx++;
      cyc++;
    end
    chk("stall_delivered", delivered, 8);

    // reset with two transactions in flight
    step(1'b1, vec(3), 4'hF, 3'd0, 4'h5, 1'b1, 1'b0, acc);
    step(1'b1, vec(10), 4'hF, 3'd3, 4'h6, 1'b1, 1'b0, acc);
    @(negedge clk); #2;
    reset = 1'b1; in_valid = 1'b0;
    q.delete(); model_ff = 4'h0; stall = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 64'h0);
    chk("mid_rst_tag", out_tag, 4'h0);
    chk("mid_rst_fflags", fflags, 4'h0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1'b1);
    repeat (5) step(1'b0, '0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0, acc);
    step(1'b1, vec(2), 4'hF, 3'd0, 4'h9, 1'b1, 1'b0, acc);
    repeat (4) step(1'b0, '0, 4'h0, 3'd0, 4'h0, 1'b1, 1'b0, acc);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
